corr_window_packer: RTL and testbench
=====================================

// Module: corr_window_packer
// PURPOSE
//   Reader end of the correlator count path. Drives window timing (o_tUpdate,
//   o_tValue) into corrCountLogdrop and captures its four window counts at
//   each window end. Serializes each snapshot as a byte packet on a
//   valid/ready stream towards the host UART/USB bridge.
// PARAMETERS
//   DATA_W   8     count width; legal 1..16. BPC = (DATA_W+7)/8 bytes per count.
//   TIME_W   8     window time width; window length = 2**TIME_W cycles.
//   SYNC     8'hA5 packet header byte.
// PORTS
//   i_clk          in   1       clock
//   i_rstn         in   1       reset, asynchronous, active-low
//   i_cg           in   1       clock-gate enable; all flops hold when 0
//   i_en           in   1       1 -> run back-to-back windows
//   o_tUpdate      out  1       window start pulse to counter
//   o_tValue       out  TIME_W  initial t, constant 0
//   i_t            in   TIME_W  counter's current t (registered there)
//   i_countX       in   DATA_W  counter outputs, sampled at window end
//   i_countY       in   DATA_W
//   i_countIsect   in   DATA_W
//   i_countSymdiff in   DATA_W
//   o_data         out  8       stream byte
//   o_valid        out  1       stream valid
//   i_ready        in   1       stream ready
//   o_nDropped     out  8       saturating count of dropped snapshots
// BEHAVIOUR
//   Reset: all flops 0 (o_valid=0, o_nDropped=0, seq=0, snapshot=0, ctrl=OFF,
//     tx=IDLE). Reset mid-packet abandons it; no partial resume.
//   Window ctrl, 2 states, advances only when i_cg=1:
//     OFF: o_tUpdate=0. i_en=1 -> RUN, asserting o_tUpdate=1 that cycle
//       (start pulse; partial window discarded, no capture).
//     RUN: END = (i_t == 2**TIME_W-1). o_tUpdate = END (combinational).
//       i_en=0 -> OFF; an END in that same cycle still captures.
//   Capture: on END & i_cg, if tx==IDLE, load snapshot {X,Y,Isect,Symdiff}
//     and seq; tx->HDR next cycle. If tx!=IDLE: snapshot untouched,
//     o_nDropped += 1 (saturates at 255). seq increments (wraps mod 256)
//     on every END, captured or dropped, so the host sees gaps.
//   Counts captured = counter registers in the END cycle (window cycles
//     0..2**TIME_W-2; last-cycle sample lost, by design).
//   TX FSM: IDLE -> HDR (o_data=SYNC) -> SEQ (o_data=seq) -> BODY
//     (4*BPC bytes: X,Y,Isect,Symdiff, each little-endian, upper bits
//     zero-padded) -> IDLE.
//     o_valid=1 in HDR/SEQ/BODY; a state/byte advances only on
//     o_valid & i_ready & i_cg. o_data stable while o_valid & !i_ready.
//     Packet length = 2+4*BPC bytes (6 for DATA_W=8).
//     Last-byte accept and a new END in the same cycle: the new snapshot is
//     captured (tx is treated as IDLE next), no drop.
//   o_tValue tied 0. Min window 2**TIME_W must exceed 2+4*BPC cycles for
//     loss-free operation with i_ready held 1.
// TESTING
//   1 TIME_W=4, ready=1, i_en=1, drive counts 3,5,1,6 -> o_tUpdate every 16
//     cycles after start pulse; bytes A5,00,03,05,01,06 then A5,01,...
//   2 i_ready toggled 1/0 each cycle -> same bytes, o_data stable while
//     stalled, no loss, o_nDropped=0.
//   3 i_ready=0 for 40 cycles, TIME_W=4 -> first packet held, two later
//     windows dropped: o_nDropped=2, next packet seq=03.
//   4 DATA_W=12, counts 0xABC,0x001,0xFFF,0x800 -> body
//     BC,0A,01,00,FF,0F,00,08.
//   5 i_rstn low mid-BODY -> o_valid=0 immediately; after release no output
//     until i_en start pulse + full window; seq restarts at 00.
//   6 i_cg=0 for 10 cycles mid-packet -> no byte accepted, seq/state
//     frozen; resumes exactly where it stopped.

Source files
------------

// File: rtl/corr_window_packer.sv
// Window timing generator and snapshot serializer for the correlator count path.
// Captures the four window counts at each window end and streams them as a byte packet.
module corr_window_packer #(
    parameter int          DATA_W = 8,
    parameter int          TIME_W = 8,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_cg,
    input  logic              i_en,
    output logic              o_tUpdate,
    output logic [TIME_W-1:0] o_tValue,
    input  logic [TIME_W-1:0] i_t,
    input  logic [DATA_W-1:0] i_countX,
    input  logic [DATA_W-1:0] i_countY,
    input  logic [DATA_W-1:0] i_countIsect,
    input  logic [DATA_W-1:0] i_countSymdiff,
    output logic [7:0]        o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [7:0]        o_nDropped,
    output logic [2:0]        o_dbg_state
);

    localparam int BPC    = (DATA_W + 7) / 8;
    localparam int PAD_W  = 8 * BPC;
    localparam int NB     = 4 * BPC;
    localparam int BODY_W = 8 * NB;
    localparam logic [2:0] LAST_IDX = 3'(NB - 1);

    typedef enum logic [0:0] {
        CTRL_OFF = 1'b0,
        CTRL_RUN = 1'b1
    } ctrl_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HDR  = 2'd1,
        TX_SEQ  = 2'd2,
        TX_BODY = 2'd3
    } tx_t;

    ctrl_t             ctrl;
    tx_t               tx;
    logic [2:0]        idx;
    logic [7:0]        seq_cnt;
    logic [7:0]        seq_pkt;
    logic [BODY_W-1:0] snap;
    logic [7:0]        dropped;

    logic              window_end;
    logic              capture_evt;
    logic              accept;
    logic              last_byte;
    logic              tx_free;
    logic [BODY_W-1:0] body_in;
    logic [PAD_W-1:0]  x_pad;
    logic [PAD_W-1:0]  y_pad;
    logic [PAD_W-1:0]  isect_pad;
    logic [PAD_W-1:0]  symdiff_pad;
    logic [7:0]        body_byte;

    // Counts are zero-extended to whole bytes; X sits in the lowest bytes so it goes out first.
    assign x_pad       = PAD_W'(i_countX);
    assign y_pad       = PAD_W'(i_countY);
    assign isect_pad   = PAD_W'(i_countIsect);
    assign symdiff_pad = PAD_W'(i_countSymdiff);
    assign body_in     = {symdiff_pad, isect_pad, y_pad, x_pad};

    assign window_end  = (i_t == {TIME_W{1'b1}});
    assign o_tUpdate   = (ctrl == CTRL_OFF) ? i_en : window_end;
    assign o_tValue    = '0;
    assign capture_evt = i_cg && (ctrl == CTRL_RUN) && window_end;

    assign o_valid     = (tx != TX_IDLE);
    assign accept      = o_valid && i_ready && i_cg;
    assign last_byte   = (tx == TX_BODY) && (idx == LAST_IDX);
    // A packet finishing in the same cycle as a window end frees the link for the new snapshot.
    assign tx_free     = (tx == TX_IDLE) || (accept && last_byte);

    assign body_byte   = 8'(snap >> {idx, 3'b000});
    assign o_nDropped  = dropped;
    assign o_dbg_state = {ctrl, tx};

    always_comb begin
        o_data = 8'h00;
        case (tx)
            TX_HDR:  o_data = SYNC;
            TX_SEQ:  o_data = seq_pkt;
            TX_BODY: o_data = body_byte;
            default: o_data = 8'h00;
        endcase
    end

    // Window control: the start pulse in OFF restarts the counter; the partial window is never captured.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ctrl <= CTRL_OFF;
        end else if (i_cg) begin
            case (ctrl)
                CTRL_OFF: if (i_en)  ctrl <= CTRL_RUN;
                CTRL_RUN: if (!i_en) ctrl <= CTRL_OFF;
                default:             ctrl <= CTRL_OFF;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tx      <= TX_IDLE;
            idx     <= 3'd0;
            seq_cnt <= 8'd0;
            seq_pkt <= 8'd0;
            snap    <= '0;
            dropped <= 8'd0;
        end else if (i_cg) begin
            if (capture_evt && tx_free) begin
                snap    <= body_in;
                seq_pkt <= seq_cnt;
                tx      <= TX_HDR;
                idx     <= 3'd0;
            end else if (accept) begin
                case (tx)
                    TX_HDR: tx <= TX_SEQ;
                    TX_SEQ: begin
                        tx  <= TX_BODY;
                        idx <= 3'd0;
                    end
                    TX_BODY: begin
                        if (last_byte) begin
                            tx  <= TX_IDLE;
                            idx <= 3'd0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                    default: tx <= TX_IDLE;
                endcase
            end

            // The sequence number advances on every window end so the host can spot drops.
            if (capture_evt) begin
                seq_cnt <= seq_cnt + 8'd1;
                if (!tx_free && dropped != 8'hFF) begin
                    dropped <= dropped + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_corr_window_packer.sv
// Bench for corr_window_packer: an 8-bit instance checked cycle by cycle against a packet-queue model,
// and a 12-bit instance checked against a table of expected packet bodies.
module tb_corr_window_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        cg;
    logic        en;
    logic        ready;
    logic [3:0]  t_cur = 4'd0;

    logic [7:0]  ax, ay, ai, asd;
    logic [11:0] bx, by, bi, bsd;

    logic        a_tupd, b_tupd;
    logic [3:0]  a_tval, b_tval;
    logic [7:0]  a_data, b_data;
    logic        a_valid, b_valid;
    logic [7:0]  a_ndrop, b_ndrop;
    logic [2:0]  a_dbg, b_dbg;

    corr_window_packer #(.DATA_W(8), .TIME_W(4), .SYNC(8'hA5)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_cg(cg), .i_en(en),
        .o_tUpdate(a_tupd), .o_tValue(a_tval), .i_t(t_cur),
        .i_countX(ax), .i_countY(ay), .i_countIsect(ai), .i_countSymdiff(asd),
        .o_data(a_data), .o_valid(a_valid), .i_ready(ready),
        .o_nDropped(a_ndrop), .o_dbg_state(a_dbg)
    );

    corr_window_packer #(.DATA_W(12), .TIME_W(4), .SYNC(8'hA5)) dut12 (
        .i_clk(clk), .i_rstn(rstn), .i_cg(cg), .i_en(en),
        .o_tUpdate(b_tupd), .o_tValue(b_tval), .i_t(t_cur),
        .i_countX(bx), .i_countY(by), .i_countIsect(bi), .i_countSymdiff(bsd),
        .o_data(b_data), .o_valid(b_valid), .i_ready(ready),
        .o_nDropped(b_ndrop), .o_dbg_state(b_dbg)
    );

    // Counter environment: t restarts at 0 after a window pulse, otherwise counts; gated like the DUT.
    always @(posedge clk) begin
        if (cg) t_cur <= a_tupd ? 4'd0 : t_cur + 4'd1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard state: expected byte queue for the 8-bit instance, captured streams of both.
    logic [7:0] exp_q[$];
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    int         seq_m   = 0;
    int         drop_m  = 0;
    int         end_cnt = 0;
    bit         run_m   = 1'b0;
    bit         hold_prev = 1'b0;
    logic [7:0] prev_data;
    bit         m_acc, m_end, m_tupd;
    logic [7:0] m_byte;

    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            got_a.delete();
            got_b.delete();
            seq_m     = 0;
            drop_m    = 0;
            run_m     = 1'b0;
            hold_prev = 1'b0;
        end else begin
            m_tupd = run_m ? (t_cur == 4'hF) : en;
            check("tupdate", a_tupd, m_tupd);
            check("tupdate_b", b_tupd, m_tupd);
            check("valid", a_valid, exp_q.size() != 0);
            check("dropped", a_ndrop, drop_m);
            if (hold_prev) begin
                check("stall_valid", a_valid, 1);
                check("stall_data", a_data, prev_data);
            end
            m_acc = cg && a_valid && ready;
            if (m_acc) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL byte_unexpected: got %0h expected no byte at %0t", a_data, $time);
                end else begin
                    m_byte = exp_q.pop_front();
                    check("byte", a_data, m_byte);
                end
                got_a.push_back(a_data);
            end
            if (cg && b_valid && ready) got_b.push_back(b_data);
            m_end = cg && run_m && (t_cur == 4'hF);
            if (m_end) begin
                end_cnt++;
                if (exp_q.size() == 0) begin
                    exp_q.push_back(8'hA5);
                    exp_q.push_back(8'(seq_m));
                    exp_q.push_back(ax);
                    exp_q.push_back(ay);
                    exp_q.push_back(ai);
                    exp_q.push_back(asd);
                end else if (drop_m < 255) begin
                    drop_m++;
                end
                seq_m = (seq_m + 1) % 256;
            end
            if (cg) run_m = en;
            hold_prev = a_valid && !m_acc;
            prev_data = a_data;
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_end();
        int start;
        bit seen;
        start = end_cnt;
        seen  = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            step(1);
            if (end_cnt != start) seen = 1'b1;
        end
        if (!seen) check("wait_end_timeout", 0, 1);
    endtask

    task automatic wait_q_len(input int len);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            step(1);
            if (exp_q.size() == len) seen = 1'b1;
        end
        if (!seen) check("wait_queue_timeout", 0, 1);
    endtask

    typedef struct {
        logic [11:0] x, y, i, s;
        logic [63:0] body;
    } row_t;

    row_t       rows[5];
    logic [7:0] first_bytes[8];
    int         mark;
    int         n_got;
    logic [7:0] hold_data;
    logic [7:0] nd0;

    initial begin
        rows[0] = '{12'hABC, 12'h001, 12'hFFF, 12'h800, 64'hBC0A_0100_FF0F_0008};
        rows[1] = '{12'h000, 12'h000, 12'h000, 12'h000, 64'h0000_0000_0000_0000};
        rows[2] = '{12'h123, 12'h456, 12'h789, 12'hFED, 64'h2301_5604_8907_ED0F};
        rows[3] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 64'hFF0F_FF0F_FF0F_FF0F};
        rows[4] = '{12'h010, 12'h100, 12'h00F, 12'hF00, 64'h1000_0001_0F00_000F};
        first_bytes = '{8'hA5, 8'h00, 8'h03, 8'h05, 8'h01, 8'h06, 8'hA5, 8'h01};

        rstn = 1'b0; cg = 1'b1; en = 1'b0; ready = 1'b1;
        ax = 8'd0; ay = 8'd0; ai = 8'd0; asd = 8'd0;
        bx = 12'd0; by = 12'd0; bi = 12'd0; bsd = 12'd0;
        step(3);
        check("reset_valid", a_valid, 0);
        check("reset_ndrop", a_ndrop, 0);
        check("reset_state", a_dbg, 0);
        check("reset_tvalue", a_tval, 0);
        check("reset_valid_b", b_valid, 0);
        check("reset_ndrop_b", b_ndrop, 0);
        check("reset_tvalue_b", b_tval, 0);
        rstn = 1'b1;
        step(5);

        // Fixed counts, ready held high: back-to-back windows, seq 00 then 01.
        ax = 8'd3; ay = 8'd5; ai = 8'd1; asd = 8'd6;
        en = 1'b1;
        step(60);
        check("phase1_len", got_a.size() >= 8, 1);
        for (int k = 0; k < 8 && k < got_a.size(); k++) check("phase1_byte", got_a[k], first_bytes[k]);

        // Last byte accepted in the same cycle as the next window end: new packet, no drop.
        wait_end();
        nd0 = a_ndrop;
        ready = 1'b0;
        step(10);
        ready = 1'b1;
        step(6);
        check("lastbyte_end_valid", a_valid, 1);
        check("lastbyte_end_hdr", a_data, 8'hA5);
        check("lastbyte_end_ndrop", a_ndrop, nd0);

        // Ready toggling every cycle with random counts: no loss.
        for (int k = 0; k < 70; k++) begin
            step(1);
            ready = ~ready;
            ax = 8'($urandom); ay = 8'($urandom); ai = 8'($urandom); asd = 8'($urandom);
        end
        ready = 1'b1;
        step(20);
        check("toggle_ndrop", a_ndrop, 0);

        // 12-bit instance: little-endian, zero-padded body bytes.
        for (int r = 0; r < 5; r++) begin
            bx = rows[r].x; by = rows[r].y; bi = rows[r].i; bsd = rows[r].s;
            ax = 8'($urandom); ay = 8'($urandom); ai = 8'($urandom); asd = 8'($urandom);
            wait_end();
            wait_end();
            mark = got_b.size();
            for (int k = 0; k < 40 && got_b.size() < mark + 10; k++) step(1);
            if (got_b.size() < mark + 10) begin
                check("b_packet_timeout", got_b.size(), mark + 10);
            end else begin
                check("b_sync", got_b[mark], 8'hA5);
                for (int k = 0; k < 8; k++) check("b_body", got_b[mark + 2 + k], rows[r].body[63 - 8 * k -: 8]);
            end
        end

        // Clock gate low mid-packet: everything freezes, then resumes.
        wait_q_len(3);
        cg = 1'b0;
        hold_data = a_data;
        n_got = got_a.size();
        step(10);
        check("cg_valid", a_valid, 1);
        check("cg_data", a_data, hold_data);
        check("cg_no_accept", got_a.size(), n_got);
        check("cg_queue", exp_q.size(), 3);
        cg = 1'b1;
        step(20);

        // Reset in the middle of the body: output drops at once, no resume.
        wait_q_len(3);
        rstn = 1'b0;
        #1;
        check("midreset_valid", a_valid, 0);
        check("midreset_ndrop", a_ndrop, 0);
        en = 1'b0;
        step(3);
        rstn = 1'b1;
        step(20);
        check("after_reset_idle", a_valid, 0);

        // Long stall: first packet held, two windows dropped, next packet carries seq 03.
        ax = 8'($urandom); ay = 8'($urandom); ai = 8'($urandom); asd = 8'($urandom);
        en = 1'b1;
        step(10);
        ready = 1'b0;
        step(40);
        ready = 1'b1;
        for (int k = 0; k < 60 && got_a.size() < 8; k++) step(1);
        check("stall_len", got_a.size() >= 8, 1);
        if (got_a.size() >= 8) begin
            check("stall_hdr0", got_a[0], 8'hA5);
            check("stall_seq0", got_a[1], 8'h00);
            check("stall_hdr1", got_a[6], 8'hA5);
            check("stall_seq1", got_a[7], 8'h03);
        end
        check("stall_ndrop", a_ndrop, 2);

        en = 1'b0;
        step(40);
        check("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
